// File: rtl/down_counter_reload_pkg.sv
// Shared definitions for the reloadable down-counter: underflow policies and
// the two-state run/idle encoding.
package down_counter_reload_pkg;

    localparam int MODE_WRAP    = 0;
    localparam int MODE_RELOAD  = 1;
    localparam int MODE_ONESHOT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_reload_sub_borrow.sv
// Combinational N-bit decrementer: adds all-ones and inverts the carry-out,
// so it lands on the same carry chain as a plain adder.
module sub_borrow #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    output logic [N-1:0] D,
    output logic         BOUT
);

    logic [N:0] sum_s;

    // A + (2^N-1): the carry is clear only when A is zero, which is the borrow
    assign sum_s = {1'b0, A} + {1'b0, {N{1'b1}}};
    assign D     = sum_s[N-1:0];
    assign BOUT  = ~sum_s[N];

endmodule

// File: rtl/down_counter_reload.sv
// Loadable down-counter/timer with a registered one-cycle borrow pulse and a
// selectable underflow policy (wrap, auto-reload or one-shot).
module down_counter_reload
    import down_counter_reload_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_WRAP
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CE,
    input  logic         LOAD,
    input  logic [N-1:0] I,
    output logic [N-1:0] O,
    output logic         ZERO,
    output logic         BOUT,
    output logic         RUNNING
);

    state_t       state_r;
    state_t       state_nxt_s;
    logic [N-1:0] count_r;
    logic [N-1:0] count_nxt_s;
    logic [N-1:0] reload_r;
    logic [N-1:0] reload_nxt_s;
    logic         bout_r;
    logic         bout_nxt_s;
    logic [N-1:0] dec_s;
    logic         borrow_s;

    sub_borrow #(.N(N)) u_sub_borrow (
        .A    (count_r),
        .D    (dec_s),
        .BOUT (borrow_s)
    );

    // Next-state selection: LOAD beats CE, and CE only counts while running
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        reload_nxt_s = reload_r;
        bout_nxt_s   = 1'b0;
        if (LOAD) begin
            count_nxt_s  = I;
            reload_nxt_s = I;
            state_nxt_s  = RUN;
        end else if ((state_r == RUN) && CE) begin
            if (borrow_s) begin
                bout_nxt_s = 1'b1;
                case (MODE)
                    MODE_WRAP:    count_nxt_s = dec_s;
                    MODE_RELOAD:  count_nxt_s = reload_r;
                    MODE_ONESHOT: begin
                        count_nxt_s = count_r;
                        state_nxt_s = IDLE;
                    end
                    default:      count_nxt_s = dec_s;
                endcase
            end else begin
                count_nxt_s = dec_s;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State, count, reload and borrow registers with asynchronous clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r  <= IDLE;
            count_r  <= {N{1'b0}};
            reload_r <= {N{1'b0}};
            bout_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            reload_r <= reload_nxt_s;
            bout_r   <= bout_nxt_s;
        end
    end

    assign O       = count_r;
    assign ZERO    = (count_r == {N{1'b0}});
    assign BOUT    = bout_r;
    assign RUNNING = (state_r == RUN);

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload across all three underflow modes
// and a 2-bit wrap instance.
module tb_down_counter_reload;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    logic       ce_a, load_a, zero_a, bout_a, run_a;
    logic [7:0] i_a, o_a;
    logic       ce_b, load_b, zero_b, bout_b, run_b;
    logic [7:0] i_b, o_b;
    logic       ce_c, load_c, zero_c, bout_c, run_c;
    logic [7:0] i_c, o_c;
    logic       ce_d, load_d, zero_d, bout_d, run_d;
    logic [1:0] i_d, o_d;

    down_counter_reload #(.N(8), .MODE(0)) u_wrap (
        .CLK(clk), .RESET(rst), .CE(ce_a), .LOAD(load_a), .I(i_a),
        .O(o_a), .ZERO(zero_a), .BOUT(bout_a), .RUNNING(run_a)
    );
    down_counter_reload #(.N(8), .MODE(1)) u_reload (
        .CLK(clk), .RESET(rst), .CE(ce_b), .LOAD(load_b), .I(i_b),
        .O(o_b), .ZERO(zero_b), .BOUT(bout_b), .RUNNING(run_b)
    );
    down_counter_reload #(.N(8), .MODE(2)) u_oneshot (
        .CLK(clk), .RESET(rst), .CE(ce_c), .LOAD(load_c), .I(i_c),
        .O(o_c), .ZERO(zero_c), .BOUT(bout_c), .RUNNING(run_c)
    );
    down_counter_reload #(.N(2), .MODE(0)) u_narrow (
        .CLK(clk), .RESET(rst), .CE(ce_d), .LOAD(load_d), .I(i_d),
        .O(o_d), .ZERO(zero_d), .BOUT(bout_d), .RUNNING(run_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wrap_o[5]   = '{2, 1, 0, 255, 254};
        int wrap_b[5]   = '{0, 0, 0, 1, 0};
        int rel_o[8]    = '{1, 0, 2, 1, 0, 2, 1, 0};
        int rel_b[8]    = '{0, 0, 1, 0, 0, 1, 0, 0};
        int nar_o[5]    = '{3, 2, 1, 0, 3};
        int nar_b[5]    = '{1, 0, 0, 0, 1};
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        ce_a = 1'b0; load_a = 1'b0; i_a = 8'd0;
        ce_b = 1'b0; load_b = 1'b0; i_b = 8'd0;
        ce_c = 1'b0; load_c = 1'b0; i_c = 8'd0;
        ce_d = 1'b0; load_d = 1'b0; i_d = 2'd0;
        #2;
        check("rst_o",    32'(o_a), 32'd0);
        check("rst_zero", 32'(zero_a), 32'd1);
        check("rst_run",  32'(run_a), 32'd0);
        check("rst_bout", 32'(bout_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // MODE 0: load 3 with CE high, wraps to 255
        load_a = 1'b1; i_a = 8'd3; ce_a = 1'b1;
        tick();
        check("wrap_load_o", 32'(o_a), 32'd3);
        check("wrap_load_b", 32'(bout_a), 32'd0);
        check("wrap_run",    32'(run_a), 32'd1);
        load_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("wrap_o",   32'(o_a), 32'(wrap_o[k]));
            check("wrap_b",   32'(bout_a), 32'(wrap_b[k]));
            check("wrap_run", 32'(run_a), 32'd1);
        end
        ce_a = 1'b0;
        tick();
        check("wrap_hold_o", 32'(o_a), 32'd254);
        check("wrap_hold_b", 32'(bout_a), 32'd0);

        // MODE 1: load 2, reloads on each underflow
        load_b = 1'b1; i_b = 8'd2; ce_b = 1'b1;
        tick();
        check("rel_load_o", 32'(o_b), 32'd2);
        load_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rel_o",    32'(o_b), 32'(rel_o[k]));
            check("rel_b",    32'(bout_b), 32'(rel_b[k]));
            check("rel_zero", 32'(zero_b), (rel_o[k] == 0) ? 32'd1 : 32'd0);
        end
        // LOAD and CE together at zero: load wins, no borrow
        load_b = 1'b1; i_b = 8'd7; ce_b = 1'b1;
        tick();
        check("prio_o", 32'(o_b), 32'd7);
        check("prio_b", 32'(bout_b), 32'd0);
        load_b = 1'b0; ce_b = 1'b0;
        tick();
        check("gap_o", 32'(o_b), 32'd7);
        check("gap_b", 32'(bout_b), 32'd0);
        ce_b = 1'b1;
        tick();
        check("gap_dec_o", 32'(o_b), 32'd6);
        // Reload value zero: borrow on every enabled edge
        load_b = 1'b1; i_b = 8'd0;
        tick();
        check("rel0_load_o", 32'(o_b), 32'd0);
        check("rel0_load_b", 32'(bout_b), 32'd0);
        load_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rel0_o", 32'(o_b), 32'd0);
            check("rel0_b", 32'(bout_b), 32'd1);
        end
        ce_b = 1'b0;
        tick();
        check("rel0_stop_b", 32'(bout_b), 32'd0);

        // MODE 2: one-shot then re-arm
        load_c = 1'b1; i_c = 8'd1; ce_c = 1'b1;
        tick();
        check("os_load_o", 32'(o_c), 32'd1);
        check("os_run",    32'(run_c), 32'd1);
        load_c = 1'b0;
        tick();
        check("os_dec_o", 32'(o_c), 32'd0);
        check("os_dec_b", 32'(bout_c), 32'd0);
        check("os_dec_r", 32'(run_c), 32'd1);
        tick();
        check("os_exp_o", 32'(o_c), 32'd0);
        check("os_exp_b", 32'(bout_c), 32'd1);
        check("os_exp_r", 32'(run_c), 32'd0);
        check("os_zero",  32'(zero_c), 32'd1);
        tick();
        check("os_idle_o", 32'(o_c), 32'd0);
        check("os_idle_b", 32'(bout_c), 32'd0);
        load_c = 1'b1; i_c = 8'd5;
        tick();
        check("os_rearm_o", 32'(o_c), 32'd5);
        check("os_rearm_r", 32'(run_c), 32'd1);
        check("os_rearm_b", 32'(bout_c), 32'd0);
        load_c = 1'b0;
        tick();
        check("os_rearm_dec", 32'(o_c), 32'd4);
        ce_c = 1'b0;

        // Asynchronous reset mid-count
        load_a = 1'b1; i_a = 8'h40;
        tick();
        check("ar_load_o", 32'(o_a), 32'h40);
        load_a = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("ar_o",    32'(o_a), 32'd0);
        check("ar_run",  32'(run_a), 32'd0);
        check("ar_zero", 32'(zero_a), 32'd1);
        check("ar_bout", 32'(bout_a), 32'd0);
        #1;
        rst = 1'b0;
        ce_a = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("ar_idle_o", 32'(o_a), 32'd0);
            check("ar_idle_b", 32'(bout_a), 32'd0);
            check("ar_idle_r", 32'(run_a), 32'd0);
        end
        ce_a = 1'b0;

        // N=2 wrap from a zero load
        load_d = 1'b1; i_d = 2'd0; ce_d = 1'b1;
        tick();
        check("nar_load_o", 32'(o_d), 32'd0);
        check("nar_zero",   32'(zero_d), 32'd1);
        check("nar_run",    32'(run_d), 32'd1);
        load_d = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("nar_o", 32'(o_d), 32'(nar_o[k]));
            check("nar_b", 32'(bout_d), 32'(nar_b[k]));
        end
        ce_d = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
